// File: rtl/multi_port_regfile.sv
// -----------------------------------------------------------------------------
// multi_port_regfile
//
// Parametrised register file for the board-level register display flow.
//   - NUM_RD registered read ports (latency 1, hold when not enabled)
//   - one byte-masked write port
//   - combinational probe port (test_addr/test_data) for the LCD display
//   - sequential clear engine that zeroes the whole array after reset or
//     on a clear_req pulse, one entry per clock
//
// Parameters
//   DATA_W    data width in bits, multiple of 8
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   NUM_RD    number of read ports, 1..4
//   ZERO_REG  1: entry 0 reads as 0 and ignores writes
//
// Optional feature macro
//   RF_WRITE_BYPASS_EN  defined: a read of the entry being written in the same
//                       cycle returns the merged (new/old byte) value.
//                       undefined: such a read returns the pre-write contents.
//
// Ports
//   clk         in   single clock
//   resetn      in   asynchronous active-low reset
//   wen         in   byte write enables, bit i -> wdata[8i+7:8i]
//   waddr       in   write address
//   wdata       in   write data
//   ren         in   per-port read enable
//   raddr       in   read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata       out  registered read data, port p at [p*DATA_W +: DATA_W]
//   test_addr   in   display probe address
//   test_data   out  raw array contents at test_addr (no latency, no bypass)
//   clear_req   in   one-cycle pulse, starts a clear sweep when idle
//   clear_busy  out  high while the sweep runs (registered)
//
// Clear FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | sweep: entry cnt written to 0 each cycle, user writes
//            | dropped, enabled read ports load 0
//   ST_IDLE  | normal operation, waits for clear_req
// -----------------------------------------------------------------------------
module multi_port_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DATA_W/8-1:0]      wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        ren,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]        test_addr,
  output logic [DATA_W-1:0]        test_data,
  input  logic                     clear_req,
  output logic                     clear_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd_next [NUM_RD];
  logic [DATA_W-1:0]   rd_q    [NUM_RD];

  // ---------------------------------------------------------------------------
  // Clear FSM. The sweep is exactly DEPTH cycles; the last entry is the one
  // where cnt is all ones, after which cnt wraps back to 0 on its own.
  // clear_req during a sweep is ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      clear_busy <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state      <= ST_IDLE;
            clear_busy <= 1'b0;
          end
        end
        default: begin
          if (clear_req) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            clear_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write path. The merged word is shared by the array update and the
  // optional read bypass so both always agree on the byte merge.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_merged = mem[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wen[i]) begin
        wr_merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Writes only land in IDLE; entry 0 is read-only when ZERO_REG is set.
  assign wr_en = (state == ST_IDLE) && (|wen) &&
                 !((ZERO_REG != 0) && (waddr == '0));

  // The array has no reset of its own: the sweep zeroes it after reset.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Next-value selection per port: array contents, optionally
  // the merged write word, forced to 0 during a sweep or for entry 0.
  // wr_en already excludes CLEAR and the zero register, so the bypass never
  // applies in those cases.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_next[p] = mem[raddr[p*ADDR_W +: ADDR_W]];
`ifdef RF_WRITE_BYPASS_EN
      if (wr_en && (waddr == raddr[p*ADDR_W +: ADDR_W])) begin
        rd_next[p] = wr_merged;
      end
`endif
      if ((state == ST_CLEAR) ||
          ((ZERO_REG != 0) && (raddr[p*ADDR_W +: ADDR_W] == '0))) begin
        rd_next[p] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (ren[p]) begin
          rd_q[p] <= rd_next[p];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rdata
    assign rdata[p*DATA_W +: DATA_W] = rd_q[p];
  end

  // ---------------------------------------------------------------------------
  // Display probe: raw array, so sweep progress is visible entry by entry.
  // ---------------------------------------------------------------------------
  assign test_data = ((ZERO_REG != 0) && (test_addr == '0)) ? '0 : mem[test_addr];

endmodule

// File: tb/tb_multi_port_regfile.sv
module tb_multi_port_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     resetn = 1'b1;
  logic [DATA_W/8-1:0]      wen = '0;
  logic [ADDR_W-1:0]        waddr = '0;
  logic [DATA_W-1:0]        wdata = '0;
  logic [NUM_RD-1:0]        ren = '0;
  logic [NUM_RD*ADDR_W-1:0] raddr = '0;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [ADDR_W-1:0]        test_addr = '0;
  logic [DATA_W-1:0]        test_data;
  logic                     clear_req = 1'b0;
  logic                     clear_busy;

  multi_port_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .test_addr(test_addr),
    .test_data(test_data), .clear_req(clear_req), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t              sb [$];
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd  [NUM_RD];
  int                m_sweep = 0;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare every read result due at this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq($sformatf("rdata%0d", e.port), rdata[e.port*DATA_W +: DATA_W], e.val);
    end
  endtask

  // One cycle of stimulus; the model produces the expected read data and
  // sweep state, then the DUT is compared after the edge.
  task automatic op(input logic [3:0] w_en, input logic [4:0] w_addr,
                    input logic [31:0] w_data, input logic [1:0] r_en,
                    input logic [4:0] a0, input logic [4:0] a1, input logic clr);
    logic [4:0]  ra [NUM_RD];
    logic [31:0] merged;
    exp_t        e;
    ra[0] = a0;
    ra[1] = a1;
    wen = w_en; waddr = w_addr; wdata = w_data;
    ren = r_en; raddr = {a1, a0}; clear_req = clr;
    merged = m_mem[w_addr];
    for (int i = 0; i < 4; i++)
      if (w_en[i]) merged[8*i +: 8] = w_data[8*i +: 8];
    for (int p = 0; p < NUM_RD; p++) begin
      if (r_en[p]) begin
        if (m_sweep > 0 || ra[p] == 0)
          m_rd[p] = '0;
        else if (BYPASS && w_en != 0 && w_addr == ra[p])
          m_rd[p] = merged;
        else
          m_rd[p] = m_mem[ra[p]];
      end
      e.port = p;
      e.val  = m_rd[p];
      sb.push_back(e);
    end
    if (m_sweep > 0) begin
      m_mem[DEPTH - m_sweep] = '0;
      m_sweep--;
    end else begin
      if (w_en != 0 && w_addr != 0) m_mem[w_addr] = merged;
      if (clr) m_sweep = DEPTH;
    end
    tick();
    check_eq("clear_busy", 32'(clear_busy), 32'(m_sweep > 0));
    wen = '0; ren = '0; clear_req = 1'b0;
  endtask

  task automatic idle_op(input logic clr);
    op(4'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, clr);
  endtask

  // Async reset asserted mid-cycle, released just after an edge.
  task automatic apply_reset(input int edges);
    #2 resetn = 1'b0;
    #1;
    check_eq("reset_busy", 32'(clear_busy), 32'd1);
    check_eq("reset_rdata0", rdata[31:0], 32'h0);
    check_eq("reset_rdata1", rdata[63:32], 32'h0);
    repeat (edges) @(posedge clk);
    #1 resetn = 1'b1;
    m_sweep = DEPTH;
    for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;
  endtask

  task automatic scan_probe(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      test_addr = 5'(a);
      #1;
      check_eq($sformatf("%s_probe%0d", tag, a), test_data, (a == 0) ? 32'h0 : m_mem[a]);
    end
  endtask

  task automatic run_sweep(input string tag, input int expected_len);
    int n = 0;
    while (clear_busy && n < 100) begin
      idle_op(1'b0);
      n++;
    end
    check_eq({tag, "_len"}, 32'(n), 32'(expected_len));
  endtask

  task automatic fill_random();
    for (int a = 1; a < DEPTH; a++)
      op(4'hF, 5'(a), $urandom | 32'h1, 2'b00, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;

    // 1: reset, 32-cycle sweep, array reads back zero
    #1;
    apply_reset(2);
    run_sweep("init_sweep", 32);
    scan_probe("init");

    // 2: full write then read on port 0
    op(4'hF, 5'd3, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 1'b0);
    op(4'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0);
    check_eq("t2_rdata0", rdata[31:0], 32'hDEADBEEF);

    // 3: byte-masked write
    op(4'b0101, 5'd3, 32'h11223344, 2'b00, 5'd0, 5'd0, 1'b0);
    test_addr = 5'd3;
    #1;
    check_eq("t3_probe", test_data, 32'hDE22BE44);
    op(4'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3, 1'b0);
    check_eq("t3_rdata1", rdata[63:32], 32'hDE22BE44);

    // hold when ren=0, ports independent
    op(4'h0, 5'd0, 32'h0, 2'b10, 5'd9, 5'd0, 1'b0);
    check_eq("hold_rdata0", rdata[31:0], 32'hDE22BE44);

    // 4: read-during-write
    op(4'hF, 5'd5, 32'hA5A5A5A5, 2'b10, 5'd0, 5'd5, 1'b0);
    check_eq("t4_rdw", rdata[63:32], BYPASS ? 32'hA5A5A5A5 : 32'h0);
    op(4'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd5, 1'b0);
    check_eq("t4_next", rdata[63:32], 32'hA5A5A5A5);
    op(4'b0011, 5'd5, 32'h00001234, 2'b01, 5'd5, 5'd0, 1'b0);

    // 5: zero register
    op(4'hF, 5'd0, 32'hFFFFFFFF, 2'b01, 5'd0, 5'd0, 1'b0);
    op(4'h0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0);
    check_eq("t5_rdata0", rdata[31:0], 32'h0);
    test_addr = 5'd0;
    #1;
    check_eq("t5_probe0", test_data, 32'h0);

    // randomised traffic with address collisions
    for (int i = 0; i < 80; i++)
      op(4'($urandom), 5'($urandom_range(0, 7)), $urandom, 2'($urandom),
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b0);
    scan_probe("rand");

    // 6a: clear_req, second pulse ignored, write during sweep lost
    fill_random();
    idle_op(1'b1);
    n = 0;
    while (clear_busy && n < 100) begin
      if (n == 3)
        idle_op(1'b1);
      else if (n == 10)
        op(4'hF, 5'd2, 32'hCAFEF00D, 2'b11, 5'd2, 5'd20, 1'b0);
      else
        op(4'h0, 5'd0, 32'h0, 2'b01, 5'(n), 5'd0, 1'b0);
      n++;
    end
    check_eq("t6_sweep_len", 32'(n), 32'd32);
    test_addr = 5'd2;
    #1;
    check_eq("t6_lost_write", test_data, 32'h0);
    scan_probe("clr");

    // 6b: reset mid-sweep restarts the sweep
    fill_random();
    idle_op(1'b1);
    repeat (5) idle_op(1'b0);
    apply_reset(2);
    n = 0;
    while (clear_busy && n < 100) begin
      if (n == 4)
        op(4'hF, 5'd1, 32'h12345678, 2'b01, 5'd1, 5'd0, 1'b0);
      else
        idle_op(1'b0);
      n++;
    end
    check_eq("t6_restart_len", 32'(n), 32'd32);
    scan_probe("rst");
    op(4'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd31, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
